// File: rtl/lpc_tpm_if.sv
// lpc_tpm_if: LAD/LFRAME# pins plus the register-file req/ack handshake of the LPC TPM target.
interface lpc_tpm_if #(parameter int ADDR_NIBBLES = 4);
   logic [3:0]                  lad_in;
   logic [3:0]                  lad_out;
   logic                        lad_oe;
   logic                        lframe_n;
   logic [4*ADDR_NIBBLES-1:0]   addr;
   logic [7:0]                  wr_data;
   logic                        wr_req;
   logic                        wr_ack;
   logic                        rd_req;
   logic                        rd_valid;
   logic [7:0]                  rd_data;
   logic                        busy;
   logic                        abort;
   logic                        sync_err;
   modport slave (input lad_in, lframe_n, wr_ack, rd_valid, rd_data,
                  output lad_out, lad_oe, addr, wr_data, wr_req, rd_req, busy, abort, sync_err);
   modport master (output lad_in, lframe_n, wr_ack, rd_valid, rd_data,
                   input lad_out, lad_oe, addr, wr_data, wr_req, rd_req, busy, abort, sync_err);
endinterface

// File: rtl/lpc_tpm_target.sv
// lpc_tpm_target: LPC TPM/I/O target with START/window decode, req/ack backend handshake and abort recovery.
// Defining LPC_SYNC_ERR_EN bounds long-wait SYNC to MAX_WAIT nibbles, then drives error SYNC.
module lpc_tpm_target #(
   parameter logic [3:0]  START_CODE   = 4'b0101,
   parameter int          ADDR_NIBBLES = 4,
   parameter logic [15:0] ADDR_BASE    = 16'hFED4,
   parameter logic [15:0] ADDR_MASK    = 16'hFFFF,
   parameter int          MAX_WAIT     = 8
) (
   input logic      clk,
   input logic      reset_n,
   lpc_tpm_if.slave bus
);
   localparam int AW = 4 * ADDR_NIBBLES;
   localparam logic [AW-1:0] L_MASK = AW'(ADDR_MASK);
   localparam logic [AW-1:0] L_BASE = AW'(ADDR_BASE & ADDR_MASK);
   localparam logic [1:0]    L_CT   = (ADDR_NIBBLES > 4) ? 2'b01 : 2'b00;

   typedef enum logic [3:0] {IDLE, START, CYCDIR, ADDR, WDATA, TARH, SYNC, RDATA, TART} state_t;

   state_t        r_state, w_st;
   logic [2:0]    r_cnt;
   logic          r_dir, r_wr_req, r_rd_req, r_done, r_lad_oe, r_abort;
   logic [3:0]    r_lad_out;
   logic [AW-1:0] r_addr, w_addr_nx;
   logic [7:0]    r_wr_data, r_rd_data;
   logic          w_ack, w_done, w_ready, w_abort, w_hit;

   if (ADDR_NIBBLES < 4 || ADDR_NIBBLES > 8 || MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_param
      $error("lpc_tpm_target: parameter out of range");
   end

   // CT/DIR arrives in the first cycle LFRAME# is high after START, so it is decoded from START.
   assign w_st      = (r_state == START && bus.lframe_n) ? CYCDIR : r_state;
   assign w_ack     = (r_wr_req & bus.wr_ack) | (r_rd_req & bus.rd_valid);
   assign w_done    = r_done | w_ack;
   assign w_abort   = !bus.lframe_n && r_state != IDLE && r_state != START;
   assign w_addr_nx = {r_addr[AW-5:0], bus.lad_in};
   assign w_hit     = (w_addr_nx & L_MASK) == L_BASE;

`ifdef LPC_SYNC_ERR_EN
   logic [7:0] r_wait;
   logic       r_err, r_sync_err;
   assign w_ready      = r_done | r_err;
   assign bus.sync_err = r_sync_err;
`else
   assign w_ready      = r_done;
   assign bus.sync_err = 1'b0;
`endif

   assign bus.lad_out = r_lad_out;
   assign bus.lad_oe  = r_lad_oe;
   assign bus.addr    = r_addr;
   assign bus.wr_data = r_wr_data;
   assign bus.wr_req  = r_wr_req;
   assign bus.rd_req  = r_rd_req;
   assign bus.busy    = r_state != IDLE;
   assign bus.abort   = r_abort;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_dir     <= 1'b0;
         r_addr    <= '0;
         r_wr_data <= '0;
         r_rd_data <= '0;
         r_wr_req  <= 1'b0;
         r_rd_req  <= 1'b0;
         r_done    <= 1'b0;
         r_lad_out <= 4'hF;
         r_lad_oe  <= 1'b0;
         r_abort   <= 1'b0;
`ifdef LPC_SYNC_ERR_EN
         r_wait     <= '0;
         r_err      <= 1'b0;
         r_sync_err <= 1'b0;
`endif
      end else begin
         r_abort <= 1'b0;
`ifdef LPC_SYNC_ERR_EN
         r_sync_err <= 1'b0;
`endif
         if (w_ack) begin
            r_wr_req <= 1'b0;
            r_rd_req <= 1'b0;
            r_done   <= 1'b1;
            if (r_rd_req) r_rd_data <= bus.rd_data;
         end
         if (w_abort) begin
            r_state   <= (bus.lad_in == START_CODE) ? START : IDLE;
            r_wr_req  <= 1'b0;
            r_rd_req  <= 1'b0;
            r_lad_oe  <= 1'b0;
            r_lad_out <= 4'hF;
            r_abort   <= 1'b1;
         end else begin
            case (w_st)
               IDLE: if (!bus.lframe_n && bus.lad_in == START_CODE) r_state <= START;
               START: r_state <= (bus.lad_in == START_CODE) ? START : IDLE;
               CYCDIR: begin
                  r_dir   <= bus.lad_in[1];
                  r_cnt   <= '0;
                  r_state <= (bus.lad_in[3:2] == L_CT) ? ADDR : IDLE;
               end
               ADDR: begin
                  r_addr <= w_addr_nx;
                  r_cnt  <= r_cnt + 3'd1;
                  if (r_cnt == 3'(ADDR_NIBBLES - 1)) begin
                     r_cnt    <= '0;
                     r_done   <= 1'b0;
                     r_rd_req <= w_hit & !r_dir;
                     r_state  <= !w_hit ? IDLE : r_dir ? WDATA : TARH;
`ifdef LPC_SYNC_ERR_EN
                     r_err <= 1'b0;
`endif
                  end
               end
               WDATA: begin
                  r_cnt <= {2'b00, !r_cnt[0]};
                  if (!r_cnt[0]) r_wr_data[3:0] <= bus.lad_in;
                  else begin
                     r_wr_data[7:4] <= bus.lad_in;
                     r_wr_req       <= 1'b1;
                     r_state        <= TARH;
                  end
               end
               TARH: begin
                  r_cnt <= {2'b00, !r_cnt[0]};
                  if (r_cnt[0]) begin
                     r_state   <= SYNC;
                     r_lad_oe  <= 1'b1;
                     r_lad_out <= w_done ? 4'h0 : 4'h6;
`ifdef LPC_SYNC_ERR_EN
                     r_wait <= 8'd1;
`endif
                  end
               end
               SYNC: begin
                  if (w_ready) begin
                     r_state   <= r_dir ? TART : RDATA;
                     r_lad_out <= r_dir ? 4'hF : r_rd_data[3:0];
                  end
                  else if (w_ack) r_lad_out <= 4'h0;
`ifdef LPC_SYNC_ERR_EN
                  else if (r_wait == 8'(MAX_WAIT)) begin
                     r_lad_out  <= 4'hA;
                     r_err      <= 1'b1;
                     r_sync_err <= 1'b1;
                     r_wr_req   <= 1'b0;
                     r_rd_req   <= 1'b0;
                     r_rd_data  <= 8'hFF;
                  end
                  else r_wait <= r_wait + 8'd1;
`endif
               end
               RDATA: begin
                  r_cnt     <= {2'b00, !r_cnt[0]};
                  r_lad_out <= r_cnt[0] ? 4'hF : r_rd_data[7:4];
                  if (r_cnt[0]) r_state <= TART;
               end
               TART: begin
                  r_cnt    <= {2'b00, !r_cnt[0]};
                  r_lad_oe <= 1'b0;
                  if (r_cnt[0]) r_state <= IDLE;
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_lpc_tpm_target.sv
// tb_lpc_tpm_target: directed and random LPC host/backend stimulus against a nibble-sequence model
// of the target's driven SYNC/data/TAR stream.
module tb_lpc_tpm_target;
   logic         clk, reset_n;
   int           n_chk, n_err, nseen, wr_cyc, rd_cyc, n_abort, n_serr, lat, age;
   logic [255:0] sig;
   logic [7:0]   rdat;
   logic [3:0]   r_sc;
   logic [1:0]   r_ct;
   logic         r_wr;
   logic [15:0]  r_a;
   logic [7:0]   r_d;
   int           r_l;

   lpc_tpm_if #(.ADDR_NIBBLES(4)) bus ();
   lpc_tpm_target dut (.clk(clk), .reset_n(reset_n), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 'h%0h required 'h%0h", tag, obs, exp);
      end
   endtask

   // One LPC clock: observe outputs, answer as the backend, then drive the host nibble.
   task automatic tick(input logic [3:0] lad, input logic lf);
      @(negedge clk);
      if (bus.lad_oe) begin
         sig = {sig[251:0], bus.lad_out};
         nseen++;
      end
      if (bus.wr_req) wr_cyc++;
      if (bus.rd_req) rd_cyc++;
      if (bus.abort) n_abort++;
      if (bus.sync_err) n_serr++;
      if (bus.wr_req || bus.rd_req) begin
         age++;
         bus.wr_ack   = bus.wr_req && lat != 0 && age == lat;
         bus.rd_valid = bus.rd_req && lat != 0 && age == lat;
      end else begin
         age          = 0;
         bus.wr_ack   = ($urandom_range(3) == 0);
         bus.rd_valid = ($urandom_range(3) == 0);
      end
      bus.rd_data  = rdat;
      bus.lad_in   = lad;
      bus.lframe_n = lf;
   endtask

   task automatic host_hdr(input logic [3:0] sc, input logic [1:0] ct, input logic wr,
                           input logic [15:0] a, input logic [7:0] d);
      tick(sc, 1'b0);
      tick({ct, wr, 1'b0}, 1'b1);
      for (int i = 3; i >= 0; i--) tick(a[i*4 +: 4], 1'b1);
      if (wr) begin
         tick(d[3:0], 1'b1);
         tick(d[7:4], 1'b1);
      end
      tick(4'hF, 1'b1);
      tick(4'hF, 1'b1);
   endtask

   // Target stream: request seen two TAR clocks before the first SYNC, so an ack lat clocks
   // after the request leaves lat-2 long-wait nibbles; then ready, read data, TAR.
   task automatic model(input bit hit, input bit wr, input logic [7:0] d, input int l,
                        output logic [255:0] s, output int n, output bit err);
      int w;
      s = '0;
      n = 0;
      err = 0;
      if (!hit) return;
      w = (l == 0) ? 1000 : (l > 2 ? l - 2 : 0);
`ifdef LPC_SYNC_ERR_EN
      if (w > 8) begin
         w = 8;
         err = 1;
      end
`endif
      for (int i = 0; i < w; i++) begin s = {s[251:0], 4'h6}; n++; end
      s = {s[251:0], err ? 4'hA : 4'h0}; n++;
      if (!wr) begin
         s = {s[251:0], err ? 4'hF : d[3:0]}; n++;
         s = {s[251:0], err ? 4'hF : d[7:4]}; n++;
      end
      s = {s[251:0], 4'hF}; n++;
   endtask

   task automatic xact(input logic [3:0] sc, input logic [1:0] ct, input logic wr, input logic [15:0] a,
                       input logic [7:0] d, input int l, input int exp_abort, input string tag);
      logic [255:0] esig;
      int en;
      bit hit, err;
      hit = (sc == 4'h5) && (ct == 2'b00) && (a == 16'hFED4);
      model(hit, wr, d, l, esig, en, err);
      lat = l; rdat = d; sig = '0; nseen = 0; wr_cyc = 0; rd_cyc = 0; n_abort = 0; n_serr = 0;
      host_hdr(sc, ct, wr, a, d);
      for (int i = 0; i < 80 && bus.busy; i++) tick(4'hF, 1'b1);
      chk({tag, ".busy_end"}, bus.busy, 1'b0);
      chk({tag, ".oe_end"}, bus.lad_oe, 1'b0);
      chk({tag, ".nibbles"}, nseen, en);
      chk({tag, ".lad_seq"}, sig, esig);
      chk({tag, ".wr_req_seen"}, wr_cyc != 0, hit && wr);
      chk({tag, ".rd_req_seen"}, rd_cyc != 0, hit && !wr);
      chk({tag, ".reqs_end"}, {bus.wr_req, bus.rd_req}, 2'b00);
      chk({tag, ".abort"}, n_abort, exp_abort);
      chk({tag, ".sync_err"}, n_serr, err);
      if (hit) chk({tag, ".addr"}, bus.addr, a);
      if (hit && wr) chk({tag, ".wr_data"}, bus.wr_data, d);
   endtask

   initial begin
      n_chk = 0; n_err = 0; lat = 0; age = 0; rdat = 8'h00; sig = '0;
      reset_n = 1'b0;
      bus.lad_in = 4'hF; bus.lframe_n = 1'b1; bus.wr_ack = 1'b0; bus.rd_valid = 1'b0; bus.rd_data = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst.lad_oe", bus.lad_oe, 1'b0);
      chk("rst.lad_out", bus.lad_out, 4'hF);
      chk("rst.busy", bus.busy, 1'b0);
      chk("rst.reqs", {bus.wr_req, bus.rd_req, bus.abort, bus.sync_err}, 4'b0000);
      chk("rst.addr", bus.addr, 16'h0000);
      chk("rst.wr_data", bus.wr_data, 8'h00);
      reset_n = 1'b1;

      xact(4'h5, 2'b00, 1'b1, 16'hFED4, 8'h3C, 1, 0, "wr_fed4");
      xact(4'h5, 2'b00, 1'b0, 16'hFED4, 8'hA5, 5, 0, "rd_fed4");
      xact(4'h5, 2'b00, 1'b0, 16'h0080, 8'h11, 1, 0, "rd_miss");
      xact(4'h0, 2'b00, 1'b1, 16'hFED4, 8'h22, 1, 0, "bad_start");
      xact(4'h5, 2'b10, 1'b0, 16'hFED4, 8'h33, 1, 0, "bad_ctype");

      tick(4'h5, 1'b0);
      tick(4'b0010, 1'b1);
      tick(4'hF, 1'b1);
      xact(4'h5, 2'b00, 1'b1, 16'hFED4, 8'h96, 2, 1, "abort_wr");

`ifdef LPC_SYNC_ERR_EN
      xact(4'h5, 2'b00, 1'b0, 16'hFED4, 8'h5A, 0, 0, "rd_timeout");
      xact(4'h5, 2'b00, 1'b1, 16'hFED4, 8'hC3, 0, 0, "wr_timeout");
`endif

      lat = 0; rdat = 8'h77;
      host_hdr(4'h5, 2'b00, 1'b0, 16'hFED4, 8'h00);
      repeat (3) tick(4'hF, 1'b1);
      chk("rst_sync.pre_oe", bus.lad_oe, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_sync.oe", bus.lad_oe, 1'b0);
      chk("rst_sync.reqs", {bus.wr_req, bus.rd_req}, 2'b00);
      chk("rst_sync.busy", bus.busy, 1'b0);
      @(negedge clk) reset_n = 1'b1;
      xact(4'h5, 2'b00, 1'b0, 16'hFED4, 8'h4E, 3, 0, "after_rst");

      for (int k = 0; k < 40; k++) begin
         r_sc = ($urandom_range(3) != 0) ? 4'h5 : 4'($urandom);
         r_ct = ($urandom_range(4) == 0) ? 2'b10 : 2'b00;
         r_wr = 1'($urandom);
         r_a  = ($urandom_range(1) != 0) ? 16'hFED4 : 16'($urandom);
         r_d  = 8'($urandom);
         r_l  = $urandom_range(12, 1);
         xact(r_sc, r_ct, r_wr, r_a, r_d, r_l, 0, $sformatf("rnd%0d", k));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/lpc_tpm_target.md
Name: lpc_tpm_target

Overview:
- Parametrised LPC target for TPM/I/O cycles; successor to the fixed single-transaction LPC peripheral.
- Adds START-code and address-window decode, and a req/ack handshake toward the register file, with long-wait SYNC while the backend is busy.
- Adds LFRAME# abort recovery and a sync-error timeout.
- Sits between the LAD/LFRAME# pins and the TPM register block.

Parameters:
- START_CODE, 4'b0101: LAD value accepted as START (TPM locality cycle); any other START is ignored.
- ADDR_NIBBLES, 4: address nibbles per cycle (4 = I/O/TPM, 8 = memory); range 4..8.
- ADDR_BASE, 16'hFED4: base of the decoded window, compared on the low 4*ADDR_NIBBLES bits.
- ADDR_MASK, 16'hFFFF: bits compared against ADDR_BASE; 0 bits are don't-care.
- MAX_WAIT, 8: long-wait SYNC cycles before error SYNC (LPC_SYNC_ERR_EN only); range 1..255.

Ports:
- clk  in  1  LPC clock, all sampling on posedge.
- reset_n  in  1  asynchronous active-low reset.
- lad_in  in  4  sampled LAD.
- lad_out  out  4  LAD value driven when lad_oe=1.
- lad_oe  out  1  LAD output enable.
- lframe_n  in  1  LFRAME#, active low.
- addr  out  4*ADDR_NIBBLES  latched cycle address; stable from req until next START.
- wr_data  out  8  latched write byte.
- wr_req  out  1  write request to backend.
- wr_ack  in  1  backend accepted write.
- rd_req  out  1  read request to backend.
- rd_valid  in  1  rd_data valid this cycle.
- rd_data  in  8  read byte.
- busy  out  1  high in every state except IDLE.
- abort  out  1  one-cycle pulse on LFRAME# abort.
- sync_err  out  1  one-cycle pulse when error SYNC is driven.

Behaviour:
- Reset (async assert, sync deassert): state IDLE; lad_oe=0; lad_out=4'hF; wr_req=rd_req=busy=abort=sync_err=0; addr=0; wr_data=0.
- lad_out/lad_oe decode only from registered state/flags; no combinational path from lad_in.
- States: IDLE, START, CYCDIR, ADDR, WDATA, TARH, SYNC, RDATA, TART.
- IDLE: lframe_n=0 and lad_in==START_CODE -> START.
- START: held while lframe_n=0; the last START nibble before lframe_n rises decides. Non-matching code -> IDLE.
- CYCDIR (1 cycle): lad_in[3:2] must be 00 for ADDR_NIBBLES=4, 01 for >4; else -> IDLE. dir latched from lad_in[1] (1=write). -> ADDR.
- ADDR: ADDR_NIBBLES cycles, MSB nibble first. On last nibble, decode (addr & ADDR_MASK)==(ADDR_BASE & ADDR_MASK). Miss -> IDLE, bus never driven. Hit -> WDATA if write, else TARH.
- WDATA: 2 cycles, low nibble first, into wr_data -> TARH.
- TARH: 2 cycles, target off bus. wr_req/rd_req rise on entry to TARH and hold until the matching wr_ack/rd_valid is sampled high, then clear next cycle. rd_data captured on rd_valid.
- SYNC, lad_oe=1: drives 4'h0 (ready) if ack/valid was sampled in any earlier cycle of the transaction, else 4'h6 (long wait) and stays. Minimum one SYNC nibble. After ready -> RDATA if read, else TART.
- RDATA: 2 cycles, rd_data[3:0] then rd_data[7:4] -> TART.
- TART: cycle 1 drives 4'hF with lad_oe=1; cycle 2 lad_oe=0 -> IDLE.
- Ack/valid while no request is pending: ignored.
- Abort: lframe_n=0 in any state other than IDLE/START. Next cycle lad_oe=0, reqs cleared, abort=1 for one cycle, state START if lad_in==START_CODE else IDLE. Abort has priority over same-cycle ack/valid.
- Back-to-back transactions: IDLE may accept START in the cycle immediately after TART.

Optional Feature:
- Macro LPC_SYNC_ERR_EN.
- Defined: 8-bit counter counts 4'h6 SYNC cycles. When the count reaches MAX_WAIT, the next SYNC nibble is 4'hA, sync_err pulses, and the req drops. Reads then drive RDATA 8'hFF; writes go to TART. Late ack is ignored.
- Undefined: long wait is unbounded; sync_err tied 0; no counter logic.

Test Plan:
- Write START 5, CYCDIR 0010, addr FED4, data 0x3C, wr_ack 1 cycle after req -> wr_data=0x3C, single SYNC 4'h0, TART 4'hF then release, busy low after.
- Read addr FED4, rd_valid with 0xA5 after 5 cycles -> 4'h6 SYNC nibbles then 4'h0, then LAD 5, A; rd_req drops after valid.
- Read addr 0x0080 (window miss), and START 4'h0 -> lad_oe never 1, no req, return to IDLE.
- Write with lframe_n pulled low during the second ADDR nibble, START 5 -> abort pulse, no wr_req, the new cycle decodes normally.
- With LPC_SYNC_ERR_EN and MAX_WAIT=8, read with no rd_valid -> eight 4'h6 nibbles, then 4'hA, sync_err pulse, data FF, rd_req cleared.
- Assert reset_n low during SYNC -> lad_oe=0 and reqs=0 immediately (asynchronously), IDLE after release.
